// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter with hold-until-release ownership.
// Define RRARB_TIMEOUT_EN to force re-arbitration after MAX_HOLD consecutive grant cycles.
module rr_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int W = $clog2(N);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t         state, state_nx;
    logic [W-1:0]   start, start_nx, win, cand, idx_nx;
    logic [N-1:0]   gnt_nx;
    logic           valid_nx, found, hold, arb;
`ifdef RRARB_TIMEOUT_EN
    logic [7:0]     cnt, cnt_nx;
`endif
    // Priority search: start first, then downward with wrap to N-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((int'(start) - k + N) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end
    // start always sits at owner-1, so a timed-out owner is naturally last in line.
`ifdef RRARB_TIMEOUT_EN
    assign hold = req[gnt_idx] && (cnt < 8'(MAX_HOLD));
`else
    assign hold = req[gnt_idx];
`endif
    assign arb = (state == IDLE) || !hold;
    always_comb begin
        state_nx = state;
        start_nx = start;
        gnt_nx   = gnt;
        valid_nx = gnt_valid;
        idx_nx   = gnt_idx;
`ifdef RRARB_TIMEOUT_EN
        cnt_nx   = (state == BUSY) ? cnt + 8'd1 : 8'd0;
`endif
        if (arb) begin
            state_nx = found ? BUSY : IDLE;
            gnt_nx   = found ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
            valid_nx = found;
            idx_nx   = found ? win : '0;
            start_nx = !found ? start : (win == '0) ? W'(N-1) : win - W'(1);
`ifdef RRARB_TIMEOUT_EN
            cnt_nx   = found ? 8'd1 : 8'd0;
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start     <= W'(N-1);
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
        end else begin
            state     <= state_nx;
            start     <= start_nx;
            gnt       <= gnt_nx;
            gnt_valid <= valid_nx;
            gnt_idx   <= idx_nx;
        end
    end
`ifdef RRARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 8'd0;
        else        cnt <= cnt_nx;
    end
`endif
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed checks of rr_arbiter with N=4, MAX_HOLD=3.
module tb_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    int         passed = 0;
    int         total = 0;

    rr_arbiter #(.N(4), .MAX_HOLD(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b want=0000", gnt); else passed++;
        total++; if (gnt_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", gnt_valid); else passed++;
        total++; if (gnt_idx !== 2'd0) $display("FAIL reset_idx got=%0d want=0", gnt_idx); else passed++;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_first_grant();
        req = 4'b0101;
        step();
        total++; if (gnt !== 4'b0100) $display("FAIL first_gnt got=%b want=0100", gnt); else passed++;
        total++; if (gnt_idx !== 2'd2) $display("FAIL first_idx got=%0d want=2", gnt_idx); else passed++;
        total++; if (gnt_valid !== 1'b1) $display("FAIL first_valid got=%b want=1", gnt_valid); else passed++;
    endtask

    task automatic test_hold_handover();
        for (int i = 0; i < 5; i++) begin
            req = (i == 2) ? 4'b0111 : 4'b0101;
            step();
            total++; if (gnt !== 4'b0100) $display("FAIL hold_%0d got=%b want=0100", i, gnt); else passed++;
        end
        req = 4'b0001;
        step();
        total++; if (gnt !== 4'b0001) $display("FAIL handover_gnt got=%b want=0001", gnt); else passed++;
        total++; if (gnt_idx !== 2'd0) $display("FAIL handover_idx got=%0d want=0", gnt_idx); else passed++;
        total++; if (gnt_valid !== 1'b1) $display("FAIL handover_valid got=%b want=1", gnt_valid); else passed++;
        req = 4'b0000;
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL release_gnt got=%b want=0000", gnt); else passed++;
        total++; if (gnt_valid !== 1'b0) $display("FAIL release_valid got=%b want=0", gnt_valid); else passed++;
        total++; if (gnt_idx !== 2'd0) $display("FAIL release_idx got=%0d want=0", gnt_idx); else passed++;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        logic [1:0] exp_i [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (gnt !== exp_g[i]) $display("FAIL rot_gnt_%0d got=%b want=%b", i, gnt, exp_g[i]); else passed++;
            total++; if (gnt_idx !== exp_i[i]) $display("FAIL rot_idx_%0d got=%0d want=%0d", i, gnt_idx, exp_i[i]); else passed++;
            req = 4'b1111 & ~exp_g[i];
        end
    endtask

    task automatic test_timeout();
`ifdef RRARB_TIMEOUT_EN
        logic [3:0] exp_g [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        logic [3:0] exp_g [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        req = 4'b0011;
        for (int i = 0; i < 7; i++) begin
            step();
            total++; if (gnt !== exp_g[i]) $display("FAIL timeout_%0d got=%b want=%b", i, gnt, exp_g[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        total++; if (gnt !== 4'b0010) $display("FAIL pre_reset got=%b want=0010", gnt); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (gnt !== 4'b0000) $display("FAIL mid_reset_gnt got=%b want=0000", gnt); else passed++;
        total++; if (gnt_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b want=0", gnt_valid); else passed++;
        req = 4'b1001;
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL held_reset got=%b want=0000", gnt); else passed++;
        rst_n = 1'b1;
        step();
        total++; if (gnt !== 4'b1000) $display("FAIL post_reset_gnt got=%b want=1000", gnt); else passed++;
        total++; if (gnt_idx !== 2'd3) $display("FAIL post_reset_idx got=%0d want=3", gnt_idx); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_hold_handover();
        test_rotation();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
